// File: rtl/demux1to8_deser.sv
// Serial-to-parallel 1:8 demultiplexer with valid/ready on both sides and a one-word holding register.
// Optional even-parity bit per word when DEMUX_PARITY_EN is defined.
module demux1to8_deser #(
   parameter int MSB_FIRST = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_perr,
   output logic [2:0] bit_cnt
);

`ifdef DEMUX_PARITY_EN
   typedef enum logic [1:0] {COLLECT, FULL, PARITY} state_t;
`else
   typedef enum logic [0:0] {COLLECT, FULL} state_t;
`endif

   state_t     state_reg;
   logic [7:0] asm_reg;
   logic [7:0] asm_next;
   logic [2:0] sel;
   logic       accept;
   logic       slot_free;

   // FULL is the only state that refuses input, so din_ready never sees out_ready.
   assign din_ready = (state_reg != FULL);
   assign accept    = din_valid && din_ready;
   assign slot_free = !out_valid || out_ready;
   assign sel       = (MSB_FIRST != 0) ? (3'd7 - bit_cnt) : bit_cnt;

   always_comb begin
      asm_next = asm_reg;
      if (accept && (state_reg == COLLECT)) begin
         asm_next[sel] = din;
      end
   end

`ifdef DEMUX_PARITY_EN
   logic perr_reg;
   logic pend_perr_reg;
   logic perr_calc;

   assign perr_calc = (^asm_reg) ^ din;
   assign out_perr  = perr_reg;
`else
   assign out_perr = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= COLLECT;
         asm_reg   <= 8'h00;
         out_data  <= 8'h00;
         out_valid <= 1'b0;
         bit_cnt   <= 3'd0;
`ifdef DEMUX_PARITY_EN
         perr_reg      <= 1'b0;
         pend_perr_reg <= 1'b0;
`endif
      end else begin
         // A take empties the holding register unless a new word lands below.
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         case (state_reg)
            COLLECT: begin
               if (accept) begin
                  asm_reg <= asm_next;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
`ifdef DEMUX_PARITY_EN
                     state_reg <= PARITY;
`else
                     if (slot_free) begin
                        out_data  <= asm_next;
                        out_valid <= 1'b1;
                     end else begin
                        state_reg <= FULL;
                     end
`endif
                  end
               end
            end
`ifdef DEMUX_PARITY_EN
            PARITY: begin
               if (accept) begin
                  if (slot_free) begin
                     out_data  <= asm_reg;
                     perr_reg  <= perr_calc;
                     out_valid <= 1'b1;
                     state_reg <= COLLECT;
                  end else begin
                     pend_perr_reg <= perr_calc;
                     state_reg     <= FULL;
                  end
               end
            end
`endif
            FULL: begin
               // out_valid is always high here, so out_ready alone means a take.
               if (out_ready) begin
                  out_data  <= asm_reg;
                  out_valid <= 1'b1;
                  bit_cnt   <= 3'd0;
                  state_reg <= COLLECT;
`ifdef DEMUX_PARITY_EN
                  perr_reg  <= pend_perr_reg;
`endif
               end
            end
            default: state_reg <= COLLECT;
         endcase
      end
   end

endmodule

// File: doc/demux1to8_deser.md
# demux1to8_deser

Serial-in, 8-bit parallel-out demultiplexer: routes each accepted input bit to the output slot addressed by an internal 3-bit select counter, then presents the assembled byte on a valid/ready output port. It is the receiving end of the 8:1 mux serializer path. Serial bits enter on a valid/ready handshake. A one-word holding register lets assembly of the next byte overlap with draining of the current one.

## Interface
- `MSB_FIRST`, default 0 — 0: first bit lands in `out_data[0]`; 1: first bit lands in `out_data[7]`.

- `clk`  in  1 — rising-edge clock, single domain.
- `rst`  in  1 — synchronous, active-high reset.
- `din`  in  1 — serial data bit.
- `din_valid`  in  1 — `din` is valid this cycle.
- `din_ready`  out  1 — block accepts `din` this cycle.
- `out_data`  out  8 — assembled byte, stable while `out_valid` is high.
- `out_valid`  out  1 — holding register is full.
- `out_ready`  in  1 — consumer takes `out_data` this cycle.
- `out_perr`  out  1 — parity error flag for `out_data`; 0 when parity is compiled out.
- `bit_cnt`  out  3 — current slot select (number of data bits assembled in the current word).

## Operation
- Accept: a bit transfers on any edge where `din_valid && din_ready`. A transfer writes `din` into assembly slot `sel`:
  - `sel = bit_cnt` when `MSB_FIRST = 0`;
  - `sel = 7 - bit_cnt` when `MSB_FIRST = 1`.
- `bit_cnt` increments on every accepted data bit and wraps 7→0.
- Output take: occurs on any edge where `out_valid && out_ready`.
- FSM states:
  - COLLECT: `din_ready = 1`. On accepting the 8th data bit (`bit_cnt == 7`), the next state depends on whether the word can be delivered:
    - If the holding register is empty, or is being taken on the same edge, the assembled byte (including the bit just accepted) loads into the holding register, `out_valid` is 1 next cycle, and the FSM stays in COLLECT.
    - Otherwise the FSM goes to FULL.
  - FULL: `din_ready = 0`; the complete word waits in the assembly register. On an output take, the word moves to the holding register, `out_valid` stays 1, and the FSM returns to COLLECT with `bit_cnt = 0`.
  - PARITY: exists only with `DEMUX_PARITY_EN`; see Configuration.
- `out_valid` clears on an output take unless a new word loads on the same edge.
- `out_data` and `out_perr` change only when a word loads into the holding register.
- `din_valid` low: no state change. Bits may be supplied with gaps of any length.
- `rst` mid-word: the partial word is discarded and the pending word is dropped.

## Timing
- Reset values:
  - `din_ready` = 1, `out_valid` = 0, `out_data` = 8'h00, `out_perr` = 0, `bit_cnt` = 0;
  - state = COLLECT; assembly register = 0.
- Latency: `out_valid` rises on the edge that accepts the final bit of a word (visible the following cycle).
- Throughput: one bit per cycle, sustained, when `out_ready` is held at 1. No bubble between words.
- `din_ready` is a registered state decode. It does not depend combinationally on `out_ready`.
- Backpressure: if a complete word sits in FULL, `din_ready` is low from the cycle after the final bit. It returns high the cycle after the output take.
- Every output is driven from a flop, except `din_ready`, which is a state decode.

## Configuration
- `DEMUX_PARITY_EN` defined:
  - After the 8th data bit the FSM enters PARITY (`din_ready = 1`, `bit_cnt` stays 0). The next accepted bit is an even-parity bit.
  - On accepting that bit, the word loads, or goes to FULL, using the same rules as COLLECT.
  - `out_perr` = XOR of the 8 data bits and the parity bit (1 means error).
  - A word is 9 accepted bits.
- `DEMUX_PARITY_EN` undefined: no PARITY state, `out_perr` is tied to 0, and a word is 8 bits.

## Test plan
- Reset, then `MSB_FIRST = 0`, `out_ready = 1`, stream bits 1,0,1,0,0,1,0,1 on consecutive cycles. Required: `out_data` = 8'hA5, `out_valid` high for exactly 1 cycle after the 8th bit, `bit_cnt` back to 0.
- `MSB_FIRST = 1`, same bit stream. Required: `out_data` = 8'hA5 with the bit order reversed in position (first bit → `out_data[7]`), i.e. 8'hA5 bit-reversed = 8'hA5 (a palindrome). Repeat with stream 1,1,0,0,0,0,0,0: required `out_data` = 8'hC0 (`MSB_FIRST = 1`) versus 8'h03 (`MSB_FIRST = 0`).
- `out_ready = 0`, stream 16 bits (byte 8'h3C, then byte 8'hF0). Required:
  - `din_ready` falls after bit 16; `out_data` = 8'h3C is held.
  - Pulse `out_ready` for 1 cycle: `out_data` = 8'hF0, `out_valid` stays 1, `din_ready` = 1 the next cycle.
- Back-to-back: stream 3 bytes continuously with `out_ready = 1`. Required: 3 single-cycle `out_valid` pulses, 8 cycles apart, no `din_ready` drop.
- Reset mid-word: assert `rst` after 5 bits. Required: `bit_cnt` = 0 and `out_valid` = 0. The next 8 bits of 8'h81 produce exactly `out_data` = 8'h81.
- With `DEMUX_PARITY_EN`: send 8'hA5 with parity bit 0 → `out_perr` = 0. Send 8'hA5 with parity bit 1 → `out_perr` = 1, and `out_valid` rises only after the 9th bit.
